// File: rtl/anton_neopixel_rx.sv
// NeoPixel single-wire receive decoder: classifies high-pulse widths into bits,
// assembles 24-bit {B,R,G} pixels and detects frame end from the latch low period.
module anton_neopixel_rx #(
    parameter int MIN_HIGH     = 1,
    parameter int BIT1_MIN     = 4,
    parameter int MAX_HIGH     = 7,
    parameter int RESET_CYCLES = 320,
    parameter int INDEX_BITS   = 13
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  neo_data_in,
    output logic [23:0]           pixel_data,
    output logic                  pixel_valid,
    output logic [INDEX_BITS-1:0] pixel_index,
    output logic                  frame_done,
    output logic                  err_glitch,
    output logic                  err_partial,
    output logic                  err_overflow
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    localparam logic [HW-1:0] H_MAX  = HW'(MAX_HIGH);
    localparam logic [HW-1:0] H_MIN  = HW'(MIN_HIGH);
    localparam logic [HW-1:0] H_ONE  = HW'(BIT1_MIN);
    localparam logic [LW-1:0] L_END  = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] L_PRE  = LW'(RESET_CYCLES - 1);
    localparam logic [4:0]    LAST_B = 5'd23;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        LOW    = 2'd1,
        HIGH   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  s1_q, s2_q, s3_q;
    logic [HW-1:0]         high_cnt_q, high_cnt_d;
    logic [LW-1:0]         low_cnt_q, low_cnt_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [INDEX_BITS-1:0] pix_cnt_q, pix_cnt_d;
    logic [23:0]           shift_q, shift_d;
    logic                  got_bit_q, got_bit_d;
    logic [23:0]           pixel_data_q, pixel_data_d;
    logic [INDEX_BITS-1:0] pixel_index_q, pixel_index_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_glitch_q, err_glitch_d;
    logic                  err_partial_q, err_partial_d;
    logic                  err_overflow_q, err_overflow_d;

    logic                  rise, fall;
    logic                  low_reach;
    logic                  hi_over, hi_short;
    logic                  bit_val;
    logic [LW-1:0]         low_inc;

    assign rise      = s2_q & ~s3_q;
    assign fall      = ~s2_q & s3_q;
    assign low_reach = ~s2_q && (low_cnt_q == L_PRE);
    assign hi_over   = s2_q && (high_cnt_q >= H_MAX);
    assign hi_short  = high_cnt_q < H_MIN;
    assign bit_val   = high_cnt_q >= H_ONE;
    assign low_inc   = (low_cnt_q == L_END) ? low_cnt_q : low_cnt_q + LW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= RESYNC;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            high_cnt_q     <= '0;
            low_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            shift_q        <= '0;
            got_bit_q      <= 1'b0;
            pixel_data_q   <= '0;
            pixel_index_q  <= '0;
            pixel_valid_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            err_glitch_q   <= 1'b0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= neo_data_in;
            s2_q           <= s1_q;
            s3_q           <= s2_q;
            high_cnt_q     <= high_cnt_d;
            low_cnt_q      <= low_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            shift_q        <= shift_d;
            got_bit_q      <= got_bit_d;
            pixel_data_q   <= pixel_data_d;
            pixel_index_q  <= pixel_index_d;
            pixel_valid_q  <= pixel_valid_d;
            frame_done_q   <= frame_done_d;
            err_glitch_q   <= err_glitch_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = RESYNC;
        end else begin
            unique case (state_q)
                RESYNC: if (low_reach) state_d = LOW;
                LOW:    if (rise) state_d = HIGH;
                HIGH: begin
                    if (hi_over || (fall && hi_short)) begin
                        state_d = RESYNC;
                    end else if (fall) begin
                        state_d = LOW;
                    end
                end
                default: state_d = RESYNC;
            endcase
        end
    end

    always_comb begin
        high_cnt_d     = high_cnt_q;
        low_cnt_d      = low_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        shift_d        = shift_q;
        got_bit_d      = got_bit_q;
        pixel_data_d   = pixel_data_q;
        pixel_index_d  = pixel_index_q;
        pixel_valid_d  = 1'b0;
        frame_done_d   = 1'b0;
        err_glitch_d   = 1'b0;
        err_partial_d  = 1'b0;
        err_overflow_d = 1'b0;

        if (!enable) begin
            high_cnt_d = '0;
            low_cnt_d  = '0;
            bit_cnt_d  = '0;
            pix_cnt_d  = '0;
            got_bit_d  = 1'b0;
        end else begin
            unique case (state_q)
                RESYNC: begin
                    low_cnt_d = s2_q ? '0 : low_inc;
                    if (low_reach) begin
                        bit_cnt_d = '0;
                        pix_cnt_d = '0;
                        got_bit_d = 1'b0;
                    end
                end
                LOW: begin
                    if (rise) begin
                        high_cnt_d = HW'(1);
                        low_cnt_d  = '0;
                    end else if (!s2_q) begin
                        low_cnt_d = low_inc;
                        // frame end: partial pixel is dropped, index restarts
                        if (low_reach) begin
                            frame_done_d  = got_bit_q;
                            err_partial_d = bit_cnt_q != '0;
                            bit_cnt_d     = '0;
                            pix_cnt_d     = '0;
                            got_bit_d     = 1'b0;
                        end
                    end
                end
                HIGH: begin
                    if (hi_over || (fall && hi_short)) begin
                        err_glitch_d = 1'b1;
                        high_cnt_d   = '0;
                        low_cnt_d    = '0;
                        bit_cnt_d    = '0;
                    end else if (fall) begin
                        shift_d[bit_cnt_q] = bit_val;
                        low_cnt_d          = LW'(1);
                        got_bit_d          = 1'b1;
                        if (bit_cnt_q == LAST_B) begin
                            pixel_data_d   = shift_d;
                            pixel_index_d  = pix_cnt_q;
                            pixel_valid_d  = 1'b1;
                            bit_cnt_d      = '0;
                            pix_cnt_d      = pix_cnt_q + INDEX_BITS'(1);
                            err_overflow_d = &pix_cnt_q;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else if (s2_q) begin
                        high_cnt_d = high_cnt_q + HW'(1);
                    end
                end
                default: begin
                    low_cnt_d = '0;
                end
            endcase
        end
    end

    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_index  = pixel_index_q;
    assign frame_done   = frame_done_q;
    assign err_glitch   = err_glitch_q;
    assign err_partial  = err_partial_q;
    assign err_overflow = err_overflow_q;

endmodule
